// File: rtl/cone_bist_ctrl.sv
// LFSR-driven BIST controller for an 18-input single-output cone: applies NPAT patterns,
// compacts responses in a 16-bit MISR, compares with GOLDEN. Option: BIST_SEED_LOAD_EN (runtime seed).
module cone_bist_ctrl #(
    parameter int unsigned NPAT   = 1024,
    parameter logic [15:0] GOLDEN = 16'h0000,
    parameter logic [17:0] SEED   = 18'h00001
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
`ifdef BIST_SEED_LOAD_EN
    input  logic [17:0] seed_i,
    input  logic        seed_ld,
`endif
    output logic [17:0] pat_o,
    input  logic        resp_i,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] sig_o
);
    typedef enum logic [2:0] {IDLE, APPLY, CAPTURE, COMPARE, DONE} state_t;

    localparam logic [17:0] SEED_NZ = (SEED == 18'h0) ? 18'h1 : SEED;
    localparam logic [15:0] NPAT_W  = 16'(NPAT);

    state_t      state_q;
    logic [17:0] pat_q;
    logic [15:0] sig_q;
    logic [15:0] cnt_q;
    logic        busy_q, done_q, pass_q;
    logic [17:0] seed_w;
    logic [17:0] lfsr_nxt;
    logic        misr_fb;

`ifdef BIST_SEED_LOAD_EN
    logic [17:0] seed_q;
    always_ff @(posedge clock) begin
        if (reset)
            seed_q <= SEED_NZ;
        else if (seed_ld && state_q == IDLE)
            seed_q <= (seed_i == 18'h0) ? 18'h1 : seed_i;
    end
    assign seed_w = seed_q;
`else
    assign seed_w = SEED_NZ;
`endif

    // pat_q doubles as the LFSR; it only advances when the next pattern is applied,
    // so pat_o keeps showing the last applied pattern once the run ends.
    assign lfsr_nxt = {pat_q[16:0], pat_q[17] ^ pat_q[10]};
    assign misr_fb  = sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10] ^ resp_i;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            sig_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else if (abort && state_q != IDLE) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // abort also wins over a simultaneous start request
                    if (start && !abort) begin
                        state_q <= APPLY;
                        pat_q   <= seed_w;
                        sig_q   <= '0;
                        cnt_q   <= '0;
                        pass_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                APPLY: state_q <= CAPTURE;
                CAPTURE: begin
                    sig_q <= {sig_q[14:0], misr_fb};
                    cnt_q <= cnt_q + 16'd1;
                    if (cnt_q + 16'd1 == NPAT_W) begin
                        state_q <= COMPARE;
                    end else begin
                        state_q <= APPLY;
                        pat_q   <= lfsr_nxt;
                    end
                end
                COMPARE: begin
                    pass_q  <= (sig_q == GOLDEN);
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pat_o = pat_q;
    assign sig_o = sig_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign pass  = pass_q;
endmodule
